// File: rtl/game_state_tx_packer.sv
// Per-frame game-state snapshot packer: emits a 9-byte AXI-stream frame
// (sync, seq, 6 payload bytes, XOR checksum) once per video frame trigger.
module game_state_tx_packer #(
  parameter logic [10:0] SEND_H    = 11'd1250,
  parameter logic [9:0]  SEND_V    = 10'd850,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic [10:0] player_x_i,
  input  logic [10:0] player_y_i,
  input  logic [8:0]  player_dir_i,
  input  logic [2:0]  game_stat_i,
  input  logic        rst_req_i,
  output logic [7:0]  axiod_o,
  output logic        axiov_o,
  output logic        axiol_o,
  input  logic        axiir_i,
  output logic        busy_o,
  output logic [7:0]  drop_count_o
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [47:0] word_q;
  logic [7:0]  seq_q;
  logic [7:0]  drop_q;
  logic [7:0]  axiod_q;
  logic        axiov_q;
  logic        axiol_q;
  logic        busy_q;

  logic        trig_d;
  logic        xfer_d;
  logic [7:0]  chk_d;
  logic [7:0]  byte_d;

  always_comb begin
    trig_d = (hcount_i == SEND_H) && (vcount_i == SEND_V);
    xfer_d = axiov_q && axiir_i;
    chk_d  = seq_q ^ word_q[47:40] ^ word_q[39:32] ^ word_q[31:24]
           ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
    // Byte to present after the one currently at idx_q transfers
    byte_d = 8'h00;
    case (idx_q)
      4'd0:    byte_d = seq_q;
      4'd1:    byte_d = word_q[47:40];
      4'd2:    byte_d = word_q[39:32];
      4'd3:    byte_d = word_q[31:24];
      4'd4:    byte_d = word_q[23:16];
      4'd5:    byte_d = word_q[15:8];
      4'd6:    byte_d = word_q[7:0];
      4'd7:    byte_d = chk_d;
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      word_q  <= 48'd0;
      seq_q   <= 8'd0;
      drop_q  <= 8'd0;
      axiod_q <= 8'd0;
      axiov_q <= 1'b0;
      axiol_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_d) begin
            word_q  <= {player_x_i, 1'b0, player_y_i, 1'b0, player_dir_i, 3'b000,
                        game_stat_i, 1'b0, rst_req_i, 3'b000, 4'b0000};
            state_q <= SEND;
            idx_q   <= 4'd0;
            axiod_q <= SYNC_BYTE;
            axiov_q <= 1'b1;
            axiol_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (trig_d && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
          end
          if (xfer_d) begin
            if (idx_q == 4'd8) begin
              state_q <= IDLE;
              idx_q   <= 4'd0;
              seq_q   <= seq_q + 8'd1;
              axiod_q <= 8'd0;
              axiov_q <= 1'b0;
              axiol_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 4'd1;
              axiod_q <= byte_d;
              axiol_q <= (idx_q == 4'd7);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axiod_o      = axiod_q;
  assign axiov_o      = axiov_q;
  assign axiol_o      = axiol_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_q;

endmodule
